// File: rtl/simon_playback.sv
// Tick-paced colour sequence playback for the memory game.
// Optional macro SIMON_PLAYBACK_GAP_EN inserts a dark tick between entries.
module simon_playback #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int COLOR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic [ADDR_W:0]    len,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [COLOR_W-1:0] wr_data,
    output logic [3:0]         led,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  step_idx
);

`ifdef SIMON_PLAYBACK_GAP_EN
    typedef enum logic [1:0] {IDLE, ALIGN, SHOW, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ALIGN, SHOW} state_t;
`endif

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t             state;
    logic [COLOR_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  idx;
    logic [ADDR_W-1:0]  nxt;
    logic [ADDR_W:0]    len_q;
    logic               accept;
    logic               last;

    function automatic logic [3:0] dec(input logic [COLOR_W-1:0] c);
        return 4'b0001 << c;
    endfunction

    assign accept   = (state == IDLE) && start && (len != '0);
    assign last     = ({1'b0, idx} == (len_q - 1'b1));
    assign nxt      = idx + 1'b1;
    assign step_idx = idx;

    // Storage has no reset; writes are locked out from the accepting cycle onwards.
    always_ff @(posedge clk) begin
        if (wr_en && (state == IDLE) && !accept)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            len_q <= '0;
            led   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        len_q <= (len > DEPTH_L) ? DEPTH_L : len;
                        idx   <= '0;
                        led   <= '0;
                        busy  <= 1'b1;
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (tick) begin
                        led   <= dec(mem[idx]);
                        state <= SHOW;
                    end
                end
                SHOW: begin
                    if (tick) begin
                        if (last) begin
                            led   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
`ifdef SIMON_PLAYBACK_GAP_EN
                            led   <= '0;
                            state <= GAP;
`else
                            idx   <= nxt;
                            led   <= dec(mem[nxt]);
`endif
                        end
                    end
                end
`ifdef SIMON_PLAYBACK_GAP_EN
                GAP: begin
                    if (tick) begin
                        idx   <= nxt;
                        led   <= dec(mem[nxt]);
                        state <= SHOW;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_playback.sv
// Self-checking bench for simon_playback: tick-count reference model plus directed literal checks.
module tb_simon_playback;
    localparam int DEPTH = 16;
`ifdef SIMON_PLAYBACK_GAP_EN
    localparam bit GAP = 1'b1;
    localparam int NT  = 8;
`else
    localparam bit GAP = 1'b0;
    localparam int NT  = 5;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1, tick = 1'b0, start = 1'b0, wr_en = 1'b0;
    logic [4:0] len = '0;
    logic [3:0] wr_addr = '0;
    logic [1:0] wr_data = '0;
    logic [3:0] led;
    logic       busy, done;
    logic [3:0] step_idx;

    int checks = 0;
    int errors = 0;

    simon_playback #(.DEPTH(16), .ADDR_W(4), .COLOR_W(2)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .len(len),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .led(led), .busy(busy), .done(done), .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: playback is described only by how many ticks have elapsed since start.
    bit         m_active = 1'b0;
    bit         m_done = 1'b0;
    bit         chk_en = 1'b0;
    int         m_k = 0;
    int         m_n = 0;
    logic [1:0] m_mem [DEPTH];

    function automatic int total_ticks(input int n);
        return GAP ? 2 * n : n + 1;
    endfunction

    function automatic logic [3:0] exp_led();
        if (!m_active || m_k == 0) return 4'b0000;
        if (GAP) begin
            if (m_k % 2 == 0) return 4'b0000;
            return 4'b0001 << m_mem[(m_k - 1) / 2];
        end
        return 4'b0001 << m_mem[m_k - 1];
    endfunction

    function automatic logic [3:0] exp_idx();
        if (!m_active || m_k == 0) return 4'd0;
        return GAP ? 4'((m_k - 1) / 2) : 4'(m_k - 1);
    endfunction

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_active = 1'b0; m_k = 0; m_done = 1'b0; chk_en = 1'b1;
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (wr_en && !(start && len != 0)) m_mem[wr_addr] = wr_data;
                if (start && len != 0) begin
                    m_active = 1'b1; m_k = 0;
                    m_n = (len > 16) ? 16 : int'(len);
                end
            end else if (tick) begin
                m_k++;
                if (m_k == total_ticks(m_n)) begin
                    m_active = 1'b0; m_done = 1'b1; m_k = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("model_led",  32'(led),      32'(exp_led()));
            check("model_busy", 32'(busy),     32'(m_active));
            check("model_done", 32'(done),     32'(m_done));
            check("model_idx",  32'(step_idx), 32'(exp_idx()));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick = 1'b1; @(negedge clk); tick = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] l);
        start = 1'b1; len = l; @(negedge clk); start = 1'b0;
    endtask

    task automatic write(input logic [3:0] a, input logic [1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d; @(negedge clk); wr_en = 1'b0;
    endtask

    task automatic finish_play(output int cnt);
        cnt = 0;
        while (busy && cnt < 64) begin
            pulse_tick();
            cnt++;
        end
        if (busy) check("finish_timeout", 32'(busy), 32'd0);
    endtask

    logic [3:0] seq [NT];

    // Plays len=4 from [2,0,3,1] with the given idle cycles between ticks.
    task automatic play_check(input string nm, input int gapcyc);
        pulse_start(5'd4);
        check({nm, "_busy0"}, 32'(busy), 32'd1);
        check({nm, "_led0"},  32'(led),  32'd0);
        for (int t = 0; t < NT; t++) begin
            idle(gapcyc);
            pulse_tick();
            if (t < NT - 1) begin
                check({nm, "_led"},  32'(led),  32'(seq[t]));
                check({nm, "_busy"}, 32'(busy), 32'd1);
                check({nm, "_done"}, 32'(done), 32'd0);
            end else begin
                check({nm, "_done_end"}, 32'(done), 32'd1);
                check({nm, "_busy_end"}, 32'(busy), 32'd0);
                check({nm, "_led_end"},  32'(led),  32'd0);
            end
        end
        idle(1);
        check({nm, "_done_once"}, 32'(done), 32'd0);
    endtask

    int cnt;

    initial begin
        if (GAP) begin
            seq[0] = 4'b0100; seq[1] = 4'b0000; seq[2] = 4'b0001; seq[3] = 4'b0000;
            seq[4] = 4'b1000; seq[5] = 4'b0000; seq[6] = 4'b0010; seq[7] = 4'b0000;
        end else begin
            seq[0] = 4'b0100; seq[1] = 4'b0001; seq[2] = 4'b1000; seq[3] = 4'b0010;
            seq[4] = 4'b0000;
        end

        idle(2);
        check("reset_led",  32'(led),      32'd0);
        check("reset_busy", 32'(busy),     32'd0);
        check("reset_done", 32'(done),     32'd0);
        check("reset_idx",  32'(step_idx), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) write(4'(i), 2'($urandom));
        write(4'd0, 2'd2); write(4'd1, 2'd0); write(4'd2, 2'd3); write(4'd3, 2'd1);

        play_check("basic", 9);

        pulse_start(5'd0);
        for (int i = 0; i < 5; i++) begin
            pulse_tick();
            check("len0_busy", 32'(busy), 32'd0);
            check("len0_done", 32'(done), 32'd0);
        end

        pulse_start(5'd20);
        finish_play(cnt);
        check("len20_ticks", 32'(cnt), GAP ? 32'd32 : 32'd17);

        start = 1'b1; len = 5'd4; tick = 1'b1;
        @(negedge clk);
        start = 1'b0; tick = 1'b0;
        check("same_cycle_led",  32'(led),  32'd0);
        check("same_cycle_busy", 32'(busy), 32'd1);
        idle(3);
        check("same_cycle_wait", 32'(led), 32'd0);
        pulse_tick();
        check("same_cycle_first", 32'(led), 32'b0100);
        finish_play(cnt);

        pulse_start(5'd4);
        write(4'd0, 2'd3);
        pulse_start(5'd2);
        pulse_tick();
        write(4'd1, 2'd2);
        finish_play(cnt);
        check("busy_ignore_len", 32'(cnt), 32'(NT - 1));

        pulse_start(5'd4);
        repeat (GAP ? 5 : 3) pulse_tick();
        check("pre_reset_led", 32'(led),      32'b1000);
        check("pre_reset_idx", 32'(step_idx), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_led",  32'(led),      32'd0);
        check("mid_reset_busy", 32'(busy),     32'd0);
        check("mid_reset_idx",  32'(step_idx), 32'd0);
        check("mid_reset_done", 32'(done),     32'd0);
        idle(2);
        play_check("replay", 0);

        for (int c = 0; c < 3000; c++) begin
            reset   = ($urandom % 400) == 0;
            tick    = ($urandom % 3) == 0;
            start   = ($urandom % 12) == 0;
            len     = 5'($urandom_range(0, 20));
            wr_en   = ($urandom % 4) == 0;
            wr_addr = 4'($urandom);
            wr_data = 2'($urandom);
            @(negedge clk);
        end
        reset = 1'b0; tick = 1'b0; start = 1'b0; wr_en = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
